// File: rtl/simon_128128.sv
// SIMON 128/128 iterative core. A loaded key is expanded into a 68-entry round-key
// file one key per clock, then blocks are encrypted or decrypted one round per clock.
module simon_128128 #(
  parameter int N  = 64,
  parameter int M  = 2,
  parameter int T  = 68,
  parameter int Co = 7
) (
  input  logic                clk,
  input  logic                nR,
  input  logic                newData,
  input  logic                newKey,
  input  logic                enc_dec,
  input  logic                readData,
  input  logic [1:0][N-1:0]   inData,
  input  logic [M-1:0][N-1:0] key,
  output logic                loadData,
  output logic                loadKey,
  output logic                doneData,
  output logic                doneKey,
  output logic [1:0][N-1:0]   outData,
  output logic [3:0]          mode
);

  typedef enum logic [3:0] {
    IDLE   = 4'b0001,
    KEYEXP = 4'b0010,
    CRYPT  = 4'b0100,
    DONE   = 4'b1000
  } state_t;

  // z2 constant sequence, bit i read left to right
  localparam logic [61:0] Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
  localparam logic [Co-1:0] LAST_KEY   = Co'(T - 3);
  localparam logic [Co-1:0] LAST_ROUND = Co'(T - 1);

  function automatic logic [N-1:0] rol(input logic [N-1:0] a, input int unsigned s);
    return (a << s) | (a >> (N - s));
  endfunction

  function automatic logic [N-1:0] ror(input logic [N-1:0] a, input int unsigned s);
    return (a >> s) | (a << (N - s));
  endfunction

  function automatic logic [N-1:0] simon_f(input logic [N-1:0] a);
    return (rol(a, 1) & rol(a, 8)) ^ rol(a, 2);
  endfunction

  state_t               state_q, state_d;
  logic [Co-1:0]        cnt_q, cnt_d;
  logic [N-1:0]         x_q, x_d, y_q, y_d;
  logic                 enc_q, enc_d;
  logic                 load_data_q, load_data_d;
  logic                 load_key_q, load_key_d;
  logic                 done_data_q, done_data_d;
  logic                 done_key_q, done_key_d;
  logic [1:0][N-1:0]    out_q, out_d;
  logic [N-1:0]         rk_q [T];

  logic                 key_cap, key_we;
  logic [N-1:0]         key_new, key_t;
  logic [5:0]           z_wrap, z_pos;
  logic [Co-1:0]        rk_idx;
  logic [N-1:0]         round_key, round_x, round_y;

  always_ff @(posedge clk) begin
    if (!nR) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      enc_q       <= 1'b0;
      load_data_q <= 1'b0;
      load_key_q  <= 1'b0;
      done_data_q <= 1'b0;
      done_key_q  <= 1'b0;
      out_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      x_q         <= x_d;
      y_q         <= y_d;
      enc_q       <= enc_d;
      load_data_q <= load_data_d;
      load_key_q  <= load_key_d;
      done_data_q <= done_data_d;
      done_key_q  <= done_key_d;
      out_q       <= out_d;
    end
  end

  always_ff @(posedge clk) begin
    if (nR && key_cap) begin
      rk_q[Co'(0)] <= key[0];
      rk_q[Co'(1)] <= key[1];
    end else if (nR && key_we) begin
      rk_q[cnt_q + Co'(2)] <= key_new;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (newKey)                  state_d = KEYEXP;
        else if (newData && done_key_q) state_d = CRYPT;
      end
      KEYEXP: if (cnt_q == LAST_KEY)   state_d = IDLE;
      CRYPT:  if (cnt_q == LAST_ROUND) state_d = DONE;
      DONE:   if (readData)            state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Round-key generation and one cipher round, both driven by the shared counter
  always_comb begin
    z_wrap    = 6'((cnt_q >= Co'(62)) ? cnt_q - Co'(62) : cnt_q);
    z_pos     = 6'd61 - z_wrap;
    key_t     = ror(rk_q[cnt_q + Co'(1)], 3);
    key_new   = ~rk_q[cnt_q] ^ key_t ^ ror(key_t, 1) ^ N'(3) ^ {{(N-1){1'b0}}, Z2[z_pos]};
    rk_idx    = enc_q ? cnt_q : LAST_ROUND - cnt_q;
    round_key = rk_q[rk_idx];
    if (enc_q) begin
      round_x = y_q ^ simon_f(x_q) ^ round_key;
      round_y = x_q;
    end else begin
      round_x = y_q;
      round_y = x_q ^ simon_f(y_q) ^ round_key;
    end
  end

  always_comb begin
    cnt_d       = cnt_q;
    x_d         = x_q;
    y_d         = y_q;
    enc_d       = enc_q;
    load_data_d = 1'b0;
    load_key_d  = 1'b0;
    done_data_d = done_data_q;
    done_key_d  = done_key_q;
    out_d       = out_q;
    key_cap     = 1'b0;
    key_we      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (newKey) begin
          key_cap    = 1'b1;
          load_key_d = 1'b1;
          done_key_d = 1'b0;
          cnt_d      = '0;
        end else if (newData && done_key_q) begin
          x_d         = inData[1];
          y_d         = inData[0];
          enc_d       = enc_dec;
          load_data_d = 1'b1;
          cnt_d       = '0;
        end
      end
      KEYEXP: begin
        key_we = 1'b1;
        cnt_d  = cnt_q + Co'(1);
        if (cnt_q == LAST_KEY) begin
          done_key_d = 1'b1;
          cnt_d      = '0;
        end
      end
      CRYPT: begin
        x_d   = round_x;
        y_d   = round_y;
        cnt_d = cnt_q + Co'(1);
        if (cnt_q == LAST_ROUND) begin
          out_d       = {round_x, round_y};
          done_data_d = 1'b1;
          cnt_d       = '0;
        end
      end
      DONE: if (readData) done_data_d = 1'b0;
      default: ;
    endcase
  end

  assign loadData = load_data_q;
  assign loadKey  = load_key_q;
  assign doneData = done_data_q;
  assign doneKey  = done_key_q;
  assign outData  = out_q;
  assign mode     = state_q;

endmodule

// File: tb/tb_simon_128128.sv
// Directed bench for simon_128128: published key vector, handshake timing,
// block streaming, decrypt round trip and reset during a crypt.
module tb_simon_128128;

  localparam logic [127:0] KEY = 128'h0F0E0D0C0B0A0908_0706050403020100;
  localparam logic [127:0] PT0 = 128'h63736564207372656C6C657661727420;
  localparam logic [127:0] CT0 = 128'h49681B1E1E54FE3F65AA832AF84E0BBC;

  logic              clk;
  logic              nR, newData, newKey, enc_dec, readData;
  logic [1:0][63:0]  inData;
  logic [1:0][63:0]  key;
  logic              loadData, loadKey, doneData, doneKey;
  logic [1:0][63:0]  outData;
  logic [3:0]        mode;

  int checks = 0;
  int failures = 0;

  logic [127:0] pt [5];
  logic [127:0] ct [5];
  logic [127:0] src_blk [5];
  logic [127:0] dst_blk [5];
  int loads_seen, dones_seen;
  logic [3:0] mode_trace [$];
  int not_onehot;

  simon_128128 dut (
    .clk(clk), .nR(nR), .newData(newData), .newKey(newKey), .enc_dec(enc_dec),
    .readData(readData), .inData(inData), .key(key), .loadData(loadData),
    .loadKey(loadKey), .doneData(doneData), .doneKey(doneKey), .outData(outData),
    .mode(mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to the next falling edge, logging mode changes and one-hot violations
  task automatic tick();
    @(negedge clk);
    if (mode_trace.size() == 0 || mode_trace[$] != mode) mode_trace.push_back(mode);
    if (!$onehot(mode)) not_onehot++;
  endtask

  task automatic run_blocks(input logic enc);
    int blk_in, blk_out;
    logic prev_done;
    blk_in = 0; blk_out = 0; prev_done = doneData;
    loads_seen = 0; dones_seen = 0;
    for (int k = 0; k < 5; k++) dst_blk[k] = '0;
    enc_dec = enc; inData = src_blk[0]; newData = 1'b1; readData = 1'b0;
    for (int c = 0; c < 800 && blk_out < 5; c++) begin
      tick();
      readData = 1'b0;
      if (loadData) begin
        loads_seen++; newData = 1'b0; blk_in++;
      end
      if (doneData && !prev_done) begin
        dones_seen++; dst_blk[blk_out] = outData; blk_out++; readData = 1'b1;
        if (blk_in < 5) begin
          inData = src_blk[blk_in]; newData = 1'b1;
        end
      end
      prev_done = doneData;
    end
  endtask

  task automatic test_reset();
    nR = 1'b0; newData = 1'b0; newKey = 1'b0; enc_dec = 1'b0; readData = 1'b0;
    inData = '0; key = '0;
    repeat (3) tick();
    checks++;
    if (mode !== 4'b0001) begin
      failures++; $display("[TB] FAIL reset_mode: got %b expected 0001", mode);
    end
    checks++;
    if ({loadData, loadKey, doneData, doneKey} !== 4'b0000) begin
      failures++; $display("[TB] FAIL reset_flags: got %b expected 0000", {loadData, loadKey, doneData, doneKey});
    end
    checks++;
    if (outData !== '0) begin
      failures++; $display("[TB] FAIL reset_outData: got %h expected 0", outData);
    end
    nR = 1'b1;
    tick();
    checks++;
    if (mode !== 4'b0001) begin
      failures++; $display("[TB] FAIL idle_after_reset: got %b expected 0001", mode);
    end
  endtask

  task automatic test_key_vector();
    int lat;
    logic [3:0] exp_trace [5];
    logic trace_ok;
    exp_trace = '{4'b0001, 4'b0010, 4'b0001, 4'b0100, 4'b1000};
    mode_trace.delete(); mode_trace.push_back(mode); not_onehot = 0;
    key = KEY; inData = PT0; enc_dec = 1'b1; newKey = 1'b1; newData = 1'b1;
    lat = -1;
    for (int c = 1; c <= 5; c++) begin tick(); if (loadKey) begin lat = c; break; end end
    checks++;
    if (lat !== 1) begin failures++; $display("[TB] FAIL loadKey_latency: got %0d expected 1", lat); end
    checks++;
    if (loadData !== 1'b0) begin failures++; $display("[TB] FAIL key_priority: loadData got %b expected 0", loadData); end
    newKey = 1'b0;
    lat = -1;
    for (int c = 1; c <= 80; c++) begin tick(); if (doneKey) begin lat = c; break; end end
    checks++;
    if (lat !== 66) begin failures++; $display("[TB] FAIL doneKey_latency: got %0d expected 66", lat); end
    lat = -1;
    for (int c = 1; c <= 5; c++) begin tick(); if (loadData) begin lat = c; break; end end
    checks++;
    if (lat !== 1) begin failures++; $display("[TB] FAIL loadData_after_key: got %0d expected 1", lat); end
    newData = 1'b0;
    lat = -1;
    for (int c = 1; c <= 80; c++) begin tick(); if (doneData) begin lat = c; break; end end
    checks++;
    if (lat !== 68) begin failures++; $display("[TB] FAIL doneData_latency: got %0d expected 68", lat); end
    checks++;
    if (outData !== CT0) begin failures++; $display("[TB] FAIL key_vector_ct: got %h expected %h", outData, CT0); end
    trace_ok = (mode_trace.size() == 5);
    for (int i = 0; i < 5 && trace_ok; i++) if (mode_trace[i] !== exp_trace[i]) trace_ok = 1'b0;
    checks++;
    if (!trace_ok) begin failures++; $display("[TB] FAIL mode_trace: got %0d transitions expected 0001>0010>0001>0100>1000", mode_trace.size()); end
    checks++;
    if (not_onehot !== 0) begin failures++; $display("[TB] FAIL mode_onehot: got %0d bad cycles expected 0", not_onehot); end
  endtask

  task automatic test_hold_release();
    int lat;
    inData = pt[1]; enc_dec = 1'b1; newData = 1'b1; readData = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      checks++;
      if (doneData !== 1'b1 || loadData !== 1'b0 || mode !== 4'b1000) begin
        failures++; $display("[TB] FAIL hold_state: got done=%b load=%b mode=%b expected 1 0 1000", doneData, loadData, mode);
      end
      checks++;
      if (outData !== CT0) begin failures++; $display("[TB] FAIL hold_outData: got %h expected %h", outData, CT0); end
    end
    readData = 1'b1;
    tick();
    readData = 1'b0;
    checks++;
    if (doneData !== 1'b0 || mode !== 4'b0001) begin
      failures++; $display("[TB] FAIL release_drop: got done=%b mode=%b expected 0 0001", doneData, mode);
    end
    checks++;
    if (outData !== CT0) begin failures++; $display("[TB] FAIL outData_after_read: got %h expected %h", outData, CT0); end
    tick();
    checks++;
    if (loadData !== 1'b1 || mode !== 4'b0100) begin
      failures++; $display("[TB] FAIL pending_load: got load=%b mode=%b expected 1 0100", loadData, mode);
    end
    newData = 1'b0;
    lat = -1;
    for (int c = 1; c <= 80; c++) begin tick(); if (doneData) begin lat = c; break; end end
    checks++;
    if (lat !== 68) begin failures++; $display("[TB] FAIL pending_latency: got %0d expected 68", lat); end
    readData = 1'b1;
    tick();
    readData = 1'b0;
  endtask

  task automatic test_back_to_back();
    int extra;
    for (int k = 0; k < 5; k++) src_blk[k] = pt[k];
    run_blocks(1'b1);
    for (int k = 0; k < 5; k++) ct[k] = dst_blk[k];
    checks++;
    if (loads_seen !== 5) begin failures++; $display("[TB] FAIL stream_loads: got %0d expected 5", loads_seen); end
    checks++;
    if (dones_seen !== 5) begin failures++; $display("[TB] FAIL stream_dones: got %0d expected 5", dones_seen); end
    checks++;
    if (ct[0] !== CT0) begin failures++; $display("[TB] FAIL stream_ct0: got %h expected %h", ct[0], CT0); end
    extra = 0;
    for (int c = 0; c < 80; c++) begin
      tick();
      readData = 1'b0;
      if (loadData || doneData) extra++;
    end
    checks++;
    if (extra !== 0) begin failures++; $display("[TB] FAIL stream_extra: got %0d extra cycles expected 0", extra); end
  endtask

  task automatic test_round_trip();
    int lat;
    nR = 1'b0;
    tick();
    nR = 1'b1;
    checks++;
    if (doneKey !== 1'b0) begin failures++; $display("[TB] FAIL rt_reset_doneKey: got %b expected 0", doneKey); end
    key = KEY; newKey = 1'b1;
    lat = -1;
    for (int c = 1; c <= 5; c++) begin tick(); if (loadKey) begin lat = c; break; end end
    newKey = 1'b0;
    lat = -1;
    for (int c = 1; c <= 80; c++) begin tick(); if (doneKey) begin lat = c; break; end end
    checks++;
    if (lat !== 66) begin failures++; $display("[TB] FAIL rt_doneKey_latency: got %0d expected 66", lat); end
    src_blk[0] = CT0;
    for (int k = 1; k < 5; k++) src_blk[k] = ct[k];
    run_blocks(1'b0);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (dst_blk[k] !== pt[k]) begin
        failures++; $display("[TB] FAIL round_trip_%0d: got %h expected %h", k, dst_blk[k], pt[k]);
      end
    end
    tick();
    readData = 1'b0;
  endtask

  task automatic test_reset_mid_crypt();
    int lat, early;
    inData = pt[2]; enc_dec = 1'b1; newData = 1'b1;
    lat = -1;
    for (int c = 1; c <= 5; c++) begin tick(); if (loadData) begin lat = c; break; end end
    newData = 1'b0;
    checks++;
    if (lat !== 1) begin failures++; $display("[TB] FAIL mid_load: got %0d expected 1", lat); end
    repeat (30) tick();
    nR = 1'b0;
    tick();
    checks++;
    if (mode !== 4'b0001 || doneKey !== 1'b0 || doneData !== 1'b0) begin
      failures++; $display("[TB] FAIL mid_reset_state: got mode=%b doneKey=%b doneData=%b expected 0001 0 0", mode, doneKey, doneData);
    end
    checks++;
    if (outData !== '0) begin failures++; $display("[TB] FAIL mid_reset_outData: got %h expected 0", outData); end
    nR = 1'b1;
    inData = PT0; newData = 1'b1;
    early = 0;
    for (int c = 0; c < 80; c++) begin tick(); if (loadData || mode !== 4'b0001) early++; end
    checks++;
    if (early !== 0) begin failures++; $display("[TB] FAIL held_off: got %0d active cycles expected 0", early); end
    key = KEY; newKey = 1'b1;
    for (int c = 1; c <= 5; c++) begin tick(); if (loadKey) break; end
    newKey = 1'b0;
    lat = -1;
    for (int c = 1; c <= 80; c++) begin tick(); if (doneKey) begin lat = c; break; end end
    lat = -1;
    for (int c = 1; c <= 5; c++) begin tick(); if (loadData) begin lat = c; break; end end
    newData = 1'b0;
    checks++;
    if (lat !== 1) begin failures++; $display("[TB] FAIL held_block_load: got %0d expected 1", lat); end
    lat = -1;
    for (int c = 1; c <= 80; c++) begin tick(); if (doneData) begin lat = c; break; end end
    checks++;
    if (lat !== 68 || outData !== CT0) begin
      failures++; $display("[TB] FAIL held_block_result: got lat=%0d %h expected 68 %h", lat, outData, CT0);
    end
    readData = 1'b1;
    tick();
    readData = 1'b0;
  endtask

  initial begin
    pt[0] = PT0;
    pt[1] = 128'hA8D5F7DE1C4A2E9077B3D015E2F86C41;
    pt[2] = 128'h5BC92D019E6F4A370D8B21C5F3A6E478;
    pt[3] = 128'hF2B48D4560C3197EAB2F5D08934E7C16;
    pt[4] = 128'h567F11DEC8A03B524E91F6D72B05A98C;
    not_onehot = 0;
    test_reset();
    test_key_vector();
    test_hold_release();
    test_back_to_back();
    test_round_trip();
    test_reset_mid_crypt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/simon_128128.md
Name: simon_128128

Overview:
- Iterative SIMON 128/128 block cipher core: 64-bit words, 2-word key, 68 rounds, one round per clock.
- Expands a loaded key into a 68-entry round-key register file, then encrypts or decrypts 128-bit blocks under a newX/loadX/doneX/readData handshake.
- Sits between a host-side data/key source and a result consumer.

Parameters:
- N, 64, word width in bits.
- M, 2, number of key words.
- T, 68, number of rounds and round keys.
- Co, 7, round/key counter width (ceil(log2 T)).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- nR  in  1  reset, synchronous, active-low.
- newData  in  1  level request: inData/enc_dec valid and a block is waiting.
- newKey  in  1  level request: key valid and a key load is waiting.
- enc_dec  in  1  1 = encrypt, 0 = decrypt; sampled with inData.
- readData  in  1  consumer has taken outData.
- inData  in  [1:0][N-1:0]  block; [1] = x (upper word), [0] = y (lower word).
- key  in  [M-1:0][N-1:0]  key; key[0] = k0, key[1] = k1.
- loadData  out  1  one-cycle pulse: block captured.
- loadKey  out  1  one-cycle pulse: key captured.
- doneData  out  1  result valid in outData, held until read.
- doneKey  out  1  round keys complete and valid.
- outData  out  [1:0][N-1:0]  result block, same word order as inData.
- mode  out  4  one-hot FSM state.

Behaviour:
- Reset (nR = 0 at an edge): state IDLE, mode = 4'b0001. All outputs 0, outData = 0, keys marked invalid. Any expansion or crypt in progress is abandoned.
- States and mode encoding: IDLE = 0001, KEYEXP = 0010, CRYPT = 0100, DONE = 1000. All outputs are registered.
- IDLE, newKey = 1 (priority over newData):
  - Capture k0 and k1 into round-key slots 0 and 1; loadKey = 1 for one cycle; doneKey = 0.
  - Go to KEYEXP with counter i = 0.
- KEYEXP: one key per edge, k[i+2] = ~k[i] ^ z2[i mod 62] ^ 3 ^ t ^ (t ror 1), where t = k[i+1] ror 3.
  - z2 = 10101111011100000011010010011000101000010001111110010110110011, bit i taken left to right, i = 0 first.
  - After 66 edges (k2..k67 written): doneKey = 1, go to IDLE.
  - doneKey stays 1 until the next key load or reset.
  - The host deasserts newKey within 66 cycles of loadKey. If newKey is still high in IDLE, a new expansion starts.
- IDLE, newKey = 0, newData = 1, doneKey = 1:
  - Capture inData and enc_dec; loadData = 1 for one cycle.
  - Go to CRYPT with round counter 0.
  - newData while doneKey = 0 is held off, not lost.
- CRYPT: one round per edge, 68 edges total, with f(a) = ((a rol 1) & (a rol 8)) ^ (a rol 2).
  - Encrypt, rounds i = 0..67: x' = y ^ f(x) ^ k[i]; y' = x.
  - Decrypt, rounds i = 67..0: x' = y; y' = x ^ f(y) ^ k[i].
  - After the last round: outData = (x, y), doneData = 1, go to DONE.
  - doneData rises 68 edges after the edge that raised loadData.
- DONE:
  - Wait for readData = 1, then doneData = 0 and go to IDLE.
  - newData and newKey are ignored in DONE and are serviced from IDLE afterwards.
  - outData holds its last result until the next completion or reset (not cleared on read).
- readData outside DONE has no effect.
- Back-to-back blocks: a newData already high when DONE exits is loaded on the next IDLE cycle. No block is lost or duplicated, provided the host drops newData within 2 cycles of loadData.
- Simultaneous newKey and newData in IDLE: key load first, the block waits for doneKey.
- Decrypt of an encrypt result under the same key returns the original plaintext bit-exactly.

Test Plan:
- Key-vector check:
  - Stimulus: reset; key[1] = 0F0E0D0C0B0A0908, key[0] = 0706050403020100; raise newKey and newData together; inData = 63736564207372656C6C657661727420, enc_dec = 1.
  - Required: loadKey pulse; doneKey after 66 cycles; then loadData.
  - Required: doneData 68 cycles after loadData with outData = 49681B1E1E54FE3F65AA832AF84E0BBC.
- Hold and release:
  - Stimulus: hold readData = 0 for 20 cycles after doneData.
  - Required: outData stable, doneData stays 1, newData not loaded.
  - Required: after readData = 1, doneData drops next edge and the pending block loads the edge after.
- Stream of five blocks: encrypt 63736564...61727420, A8D5F7DE..., 5BC92D01..., F2B48D45..., 567F11DE... back-to-back.
  - Required: exactly five loadData and five doneData pulses, results in order.
- Round trip:
  - Stimulus: reset; reload the same key; decrypt each of the five ciphertexts (enc_dec = 0).
  - Required: outputs equal the original plaintexts; 49681B1E...0BBC decrypts to 63736564...61727420.
- Reset mid-CRYPT:
  - Stimulus: nR = 0 at round 30.
  - Required: mode = 0001, doneKey = 0, doneData = 0, outData = 0.
  - Required: newData is not accepted until a new key expansion completes.
- Mode trace: mode goes 0001 → 0010 → 0001 → 0100 → 1000 → 0001 across one key load and one block; exactly one bit is set at all times.
